sram_tp_arb_ctrl: RTL and testbench
===================================

Name: sram_tp_arb_ctrl

Overview:
Two-client arbiter and sequencer for the two-port SRAM simulation/behavioural model. It shares the SRAM write port between two write clients and the SRAM read port between two read clients, using independent round-robin arbitration per port. It tags every issued read and routes the returned data back to the originating client after the SRAM read latency. It also resolves same-cycle read/write address collisions so that a read always returns the most recently written data.

Parameters:
SIZE, 256, SRAM depth in words; SIZE_WD = FUNC_LOG2(SIZE)
DATA_WD, 32, SRAM word width
RD_LAT, 1, SRAM read latency in cycles: 1 when the SRAM has its output register off, 2 when on; only 1 and 2 are legal

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
wr0_val_i  in  1  write client 0 request
wr0_adr_i  in  SIZE_WD  write client 0 address
wr0_dat_i  in  DATA_WD  write client 0 data
wr0_rdy_o  out  1  write client 0 accepted this cycle
wr1_val_i / wr1_adr_i / wr1_dat_i / wr1_rdy_o  same as client 0, for client 1
rd0_val_i  in  1  read client 0 request
rd0_adr_i  in  SIZE_WD  read client 0 address
rd0_rdy_o  out  1  read client 0 accepted this cycle
rd1_val_i / rd1_adr_i / rd1_rdy_o  same as client 0, for client 1
rd0_rsp_o  out  1  read data on rd_dat_o belongs to client 0
rd1_rsp_o  out  1  read data on rd_dat_o belongs to client 1
rd_dat_o  out  DATA_WD  returned read data, shared by both clients
sram_wr_val_o  out  1  SRAM write enable
sram_wr_adr_o  out  SIZE_WD  SRAM write address
sram_wr_dat_o  out  DATA_WD  SRAM write data
sram_rd_val_o  out  1  SRAM read enable
sram_rd_adr_o  out  SIZE_WD  SRAM read address
sram_rd_val_i  in  1  SRAM read-data valid
sram_rd_dat_i  in  DATA_WD  SRAM read data
err_o  out  1  sticky protocol error flag

Behaviour:
- Handshake
  - A request transfers in the cycle where val and rdy are both high.
  - One word per transfer.
  - rdy is a combinational function of the val inputs and the arbiter state.
  - A client holds val, adr and dat stable until rdy is seen.
- Write arbitration
  - Round-robin pointer wptr, 1 bit, reset value 0.
  - If only one client requests, it is granted.
  - If both request, client wptr is granted.
  - On any grant, wptr <= ~granted_index.
  - Granted request drives sram_wr_* combinationally in the same cycle.
- Read arbitration
  - Round-robin pointer rptr, same rules as wptr.
  - A granted read drives sram_rd_val_o=1 and sram_rd_adr_o combinationally.
- Collision rule
  - Applies when a write is granted and the read candidate's address equals the granted write address in the same cycle.
  - No read is granted that cycle: both rd*_rdy_o=0 and sram_rd_val_o=0.
  - rptr is not updated.
  - The read issues on a later cycle and returns the new data.
  - Writes are never stalled.
- Tag pipeline
  - Shift register of RD_LAT stages, each stage {vld, id}.
  - Stage 0 is loaded with {sram_rd_val_o, granted_read_index} every cycle.
  - Data returns exactly RD_LAT cycles after acceptance.
- Response
  - Combinational from the pipeline tail and SRAM outputs.
  - rdN_rsp_o = tail.vld & (tail.id==N).
  - rd_dat_o = sram_rd_dat_i.
- Error flag
  - err_o sets when tail.vld != sram_rd_val_i.
  - Cleared only by rst.
- Reset (rst=1)
  - All rdy outputs and sram_wr_val_o / sram_rd_val_o are forced 0.
  - rd*_rsp_o=0 and err_o=0.
  - wptr=0, rptr=0, and all tag stages cleared.
  - The *_adr_o / *_dat_o outputs are don't-care.
- Reset mid-operation
  - In-flight reads are discarded; no response is produced for them.
  - The bench must also reset the SRAM.
- Throughput: at most 1 write and 1 read per cycle, each sustainable every cycle.

Test Plan:
1. rst for 3 cycles, then idle -> all rdy, sram val, rsp and err_o stay 0; wptr=rptr=0.
2. RD_LAT=1: wr0 writes adr 5 / dat 0xA5A5A5A5, then rd1 reads adr 5 -> rd1_rdy_o=1; exactly 1 cycle later rd1_rsp_o=1, rd0_rsp_o=0, rd_dat_o=0xA5A5A5A5.
3. wr0 and wr1 held valid for 4 cycles (adr 1..4) -> grants alternate 0,1,0,1; sram_wr_val_o=1 in every cycle.
4. Collision: same cycle wr0 writes adr 7 / 0x11 (old content 0x22) and rd0 reads adr 7 -> rd0_rdy_o=0 that cycle, granted next cycle, response data 0x11; a different read address (8) is not stalled.
5. RD_LAT=2, rd0 and rd1 back-to-back for 4 cycles -> responses arrive 2 cycles after each accept, in accept order with correct ids; with sram_rd_val_i forced 0 on one slot, err_o=1 and stays set until rst.
6. rst asserted the cycle after a read accept -> no rd*_rsp_o is produced; after release, a new read completes normally.

Source files
------------

// File: rtl/sram_tp_arb_ctrl.sv
// Two-client round-robin arbiter/sequencer for a two-port SRAM: one write port, one read port,
// read tagging with in-order response routing, and read-after-write collision stalling.
module sram_tp_arb_ctrl #(
  parameter int SIZE     = 256,
  parameter int DATA_WD  = 32,
  parameter int RD_LAT   = 1,
  localparam int SIZE_WD = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr0_val_i,
  input  logic [SIZE_WD-1:0] wr0_adr_i,
  input  logic [DATA_WD-1:0] wr0_dat_i,
  output logic               wr0_rdy_o,
  input  logic               wr1_val_i,
  input  logic [SIZE_WD-1:0] wr1_adr_i,
  input  logic [DATA_WD-1:0] wr1_dat_i,
  output logic               wr1_rdy_o,
  input  logic               rd0_val_i,
  input  logic [SIZE_WD-1:0] rd0_adr_i,
  output logic               rd0_rdy_o,
  input  logic               rd1_val_i,
  input  logic [SIZE_WD-1:0] rd1_adr_i,
  output logic               rd1_rdy_o,
  output logic               rd0_rsp_o,
  output logic               rd1_rsp_o,
  output logic [DATA_WD-1:0] rd_dat_o,
  output logic               sram_wr_val_o,
  output logic [SIZE_WD-1:0] sram_wr_adr_o,
  output logic [DATA_WD-1:0] sram_wr_dat_o,
  output logic               sram_rd_val_o,
  output logic [SIZE_WD-1:0] sram_rd_adr_o,
  input  logic               sram_rd_val_i,
  input  logic [DATA_WD-1:0] sram_rd_dat_i,
  output logic               err_o
);

  logic [1:0]         wr_req;
  logic [1:0]         rd_req;
  logic [SIZE_WD-1:0] wr_adr [2];
  logic [DATA_WD-1:0] wr_dat [2];
  logic [SIZE_WD-1:0] rd_adr [2];

  logic               wptr_reg, wptr_next;
  logic               rptr_reg, rptr_next;
  logic               wr_any, wr_idx;
  logic               rd_any, rd_idx, rd_go;
  logic               collision;
  logic [SIZE_WD-1:0] wr_adr_sel, rd_adr_sel;
  logic [DATA_WD-1:0] wr_dat_sel;
  logic [1:0]         wr_gnt, rd_gnt, rsp;

  logic [RD_LAT-1:0]  tag_vld_reg, tag_vld_next;
  logic [RD_LAT-1:0]  tag_id_reg, tag_id_next;
  logic               tail_vld, tail_id;
  logic               err_reg;

  // Requests are masked during reset so nothing is granted or issued to the SRAM.
  assign wr_req    = {wr1_val_i, wr0_val_i} & {2{~rst}};
  assign rd_req    = {rd1_val_i, rd0_val_i} & {2{~rst}};
  assign wr_adr[0] = wr0_adr_i;
  assign wr_adr[1] = wr1_adr_i;
  assign wr_dat[0] = wr0_dat_i;
  assign wr_dat[1] = wr1_dat_i;
  assign rd_adr[0] = rd0_adr_i;
  assign rd_adr[1] = rd1_adr_i;

  // Pointer only matters on a tie; a lone requester always wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    if (req == 2'b11) return ptr;
    return req[1];
  endfunction

  always_comb begin
    wr_any     = |wr_req;
    wr_idx     = rr_pick(wr_req, wptr_reg);
    wr_adr_sel = wr_adr[wr_idx];
    wr_dat_sel = wr_dat[wr_idx];
    rd_any     = |rd_req;
    rd_idx     = rr_pick(rd_req, rptr_reg);
    rd_adr_sel = rd_adr[rd_idx];
    // Hold the read back one cycle so it sees the word being written now.
    collision  = wr_any & rd_any & (rd_adr_sel == wr_adr_sel);
    rd_go      = rd_any & ~collision;
    wptr_next  = wr_any ? ~wr_idx : wptr_reg;
    rptr_next  = rd_go  ? ~rd_idx : rptr_reg;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_client
    assign wr_gnt[gi] = wr_any & (wr_idx == 1'(gi));
    assign rd_gnt[gi] = rd_go  & (rd_idx == 1'(gi));
    assign rsp[gi]    = tail_vld & (tail_id == 1'(gi)) & ~rst;
  end

  assign wr0_rdy_o     = wr_gnt[0];
  assign wr1_rdy_o     = wr_gnt[1];
  assign rd0_rdy_o     = rd_gnt[0];
  assign rd1_rdy_o     = rd_gnt[1];
  assign sram_wr_val_o = wr_any;
  assign sram_wr_adr_o = wr_adr_sel;
  assign sram_wr_dat_o = wr_dat_sel;
  assign sram_rd_val_o = rd_go;
  assign sram_rd_adr_o = rd_adr_sel;

  // Tag shift register: stage 0 captures the issued read, tail lines up with SRAM data.
  always_comb begin
    tag_vld_next    = tag_vld_reg << 1;
    tag_id_next     = tag_id_reg << 1;
    tag_vld_next[0] = rd_go;
    tag_id_next[0]  = rd_idx;
  end

  assign tail_vld  = tag_vld_reg[RD_LAT-1];
  assign tail_id   = tag_id_reg[RD_LAT-1];
  assign rd0_rsp_o = rsp[0];
  assign rd1_rsp_o = rsp[1];
  assign rd_dat_o  = sram_rd_dat_i;
  assign err_o     = err_reg & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg    <= 1'b0;
      rptr_reg    <= 1'b0;
      tag_vld_reg <= '0;
      tag_id_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      wptr_reg    <= wptr_next;
      rptr_reg    <= rptr_next;
      tag_vld_reg <= tag_vld_next;
      tag_id_reg  <= tag_id_next;
      err_reg     <= err_reg | (tail_vld != sram_rd_val_i);
    end
  end

endmodule

// File: tb/tb_sram_tp_arb_ctrl.sv
// Directed bench: one DUT with RD_LAT=1 (index 0) and one with RD_LAT=2 (index 1), each with an SRAM model.
module tb_sram_tp_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr0_val, wr1_val, rd0_val, rd1_val, kill;
  logic [7:0]  wr0_adr [2], wr1_adr [2], rd0_adr [2], rd1_adr [2];
  logic [31:0] wr0_dat [2], wr1_dat [2];
  logic [1:0]  wr0_rdy, wr1_rdy, rd0_rdy, rd1_rdy, rd0_rsp, rd1_rsp;
  logic [1:0]  sram_wr_val, sram_rd_val, sram_rd_vld, err;
  logic [7:0]  sram_wr_adr [2], sram_rd_adr [2];
  logic [31:0] sram_wr_dat [2], sram_rd_dat [2], rd_dat [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    logic [31:0] mem [256];
    logic [1:0]  pv;
    logic [31:0] pd [2];

    sram_tp_arb_ctrl #(.SIZE(256), .DATA_WD(32), .RD_LAT(gi + 1)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .wr0_val_i     (wr0_val[gi]),
      .wr0_adr_i     (wr0_adr[gi]),
      .wr0_dat_i     (wr0_dat[gi]),
      .wr0_rdy_o     (wr0_rdy[gi]),
      .wr1_val_i     (wr1_val[gi]),
      .wr1_adr_i     (wr1_adr[gi]),
      .wr1_dat_i     (wr1_dat[gi]),
      .wr1_rdy_o     (wr1_rdy[gi]),
      .rd0_val_i     (rd0_val[gi]),
      .rd0_adr_i     (rd0_adr[gi]),
      .rd0_rdy_o     (rd0_rdy[gi]),
      .rd1_val_i     (rd1_val[gi]),
      .rd1_adr_i     (rd1_adr[gi]),
      .rd1_rdy_o     (rd1_rdy[gi]),
      .rd0_rsp_o     (rd0_rsp[gi]),
      .rd1_rsp_o     (rd1_rsp[gi]),
      .rd_dat_o      (rd_dat[gi]),
      .sram_wr_val_o (sram_wr_val[gi]),
      .sram_wr_adr_o (sram_wr_adr[gi]),
      .sram_wr_dat_o (sram_wr_dat[gi]),
      .sram_rd_val_o (sram_rd_val[gi]),
      .sram_rd_adr_o (sram_rd_adr[gi]),
      .sram_rd_val_i (sram_rd_vld[gi]),
      .sram_rd_dat_i (sram_rd_dat[gi]),
      .err_o         (err[gi])
    );

    // SRAM model: write on the edge, read data appears gi+1 cycles after the read enable.
    always @(posedge clk) begin
      if (sram_wr_val[gi]) mem[sram_wr_adr[gi]] <= sram_wr_dat[gi];
      if (rst) begin
        pv <= 2'b00;
      end else begin
        pv[0] <= sram_rd_val[gi];
        pv[1] <= pv[0];
        pd[0] <= mem[sram_rd_adr[gi]];
        pd[1] <= pd[0];
      end
    end
    assign sram_rd_vld[gi] = pv[gi] & ~kill[gi];
    assign sram_rd_dat[gi] = pd[gi];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    wr0_val = 2'b00;
    wr1_val = 2'b00;
    rd0_val = 2'b00;
    rd1_val = 2'b00;
    kill    = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h, expected 0x%08h", n_chk, 0);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    idle_all();
    for (int i = 0; i < 2; i++) begin
      wr0_adr[i] = '0; wr1_adr[i] = '0; rd0_adr[i] = '0; rd1_adr[i] = '0;
      wr0_dat[i] = '0; wr1_dat[i] = '0;
    end

    // Reset with requests pending: nothing may be granted or issued.
    wr0_val = 2'b11;
    rd1_val = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_wr_rdy", 32'({wr0_rdy, wr1_rdy}), 32'd0);
      check("rst_rd_rdy", 32'({rd0_rdy, rd1_rdy}), 32'd0);
      check("rst_sram_val", 32'({sram_wr_val, sram_rd_val}), 32'd0);
      check("rst_rsp_err", 32'({rd0_rsp, rd1_rsp, err}), 32'd0);
      step();
    end
    rst = 1'b0;
    idle_all();
    repeat (2) begin
      @(negedge clk);
      check("idle_out", 32'({wr0_rdy, wr1_rdy, rd0_rdy, rd1_rdy, sram_wr_val, sram_rd_val,
                             rd0_rsp, rd1_rsp, err}), 32'd0);
      step();
    end

    // Both writers held valid: grants alternate 0,1,0,1 starting from wptr=0.
    wr0_val[0] = 1'b1; wr0_adr[0] = 8'd1; wr0_dat[0] = 32'h100;
    wr1_val[0] = 1'b1; wr1_adr[0] = 8'd2; wr1_dat[0] = 32'h200;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rr_wr0_rdy", 32'(wr0_rdy[0]), 32'(c % 2 == 0));
      check("rr_wr1_rdy", 32'(wr1_rdy[0]), 32'(c % 2 == 1));
      check("rr_wr_val", 32'(sram_wr_val[0]), 32'd1);
      check("rr_wr_adr", 32'(sram_wr_adr[0]), 32'(c + 1));
      check("rr_wr_dat", sram_wr_dat[0], 32'((c + 1) * 256));
      step();
      if (c % 2 == 0) begin
        wr0_adr[0] = 8'(c + 3); wr0_dat[0] = 32'((c + 3) * 256);
      end else begin
        wr1_adr[0] = 8'(c + 3); wr1_dat[0] = 32'((c + 3) * 256);
      end
    end
    idle_all();

    // Write then read on RD_LAT=1: response exactly one cycle after accept.
    wr0_val[0] = 1'b1; wr0_adr[0] = 8'd5; wr0_dat[0] = 32'hA5A5A5A5;
    @(negedge clk);
    check("w5_rdy", 32'(wr0_rdy[0]), 32'd1);
    step();
    wr0_val[0] = 1'b0; rd1_val[0] = 1'b1; rd1_adr[0] = 8'd5;
    @(negedge clk);
    check("r5_rdy", 32'({rd1_rdy[0], rd0_rdy[0]}), 32'b10);
    check("r5_sram", 32'({sram_rd_val[0], sram_rd_adr[0]}), 32'h105);
    check("r5_early_rsp", 32'(rd1_rsp[0]), 32'd0);
    step();
    rd1_val[0] = 1'b0;
    @(negedge clk);
    check("r5_rsp", 32'({rd1_rsp[0], rd0_rsp[0]}), 32'b10);
    check("r5_dat", rd_dat[0], 32'hA5A5A5A5);
    step();
    @(negedge clk);
    check("r5_rsp_done", 32'(rd1_rsp[0]), 32'd0);

    // Collision: seed adr 7 = 0x22 and adr 8 = 0x88.
    wr1_val[0] = 1'b1; wr1_adr[0] = 8'd7; wr1_dat[0] = 32'h22;
    step();
    wr1_adr[0] = 8'd8; wr1_dat[0] = 32'h88;
    step();
    wr1_val[0] = 1'b0;
    wr0_val[0] = 1'b1; wr0_adr[0] = 8'd7; wr0_dat[0] = 32'h11;
    rd0_val[0] = 1'b1; rd0_adr[0] = 8'd7;
    @(negedge clk);
    check("col_wr_rdy", 32'(wr0_rdy[0]), 32'd1);
    check("col_rd_stall", 32'({rd0_rdy[0], rd1_rdy[0], sram_rd_val[0]}), 32'd0);
    step();
    wr0_val[0] = 1'b0;
    @(negedge clk);
    check("col_rd_rdy", 32'(rd0_rdy[0]), 32'd1);
    check("col_rd_adr", 32'(sram_rd_adr[0]), 32'd7);
    step();
    rd0_val[0] = 1'b0;
    @(negedge clk);
    check("col_rsp", 32'({rd0_rsp[0], rd1_rsp[0]}), 32'b10);
    check("col_dat", rd_dat[0], 32'h11);
    step();
    wr0_val[0] = 1'b1; wr0_adr[0] = 8'd7; wr0_dat[0] = 32'h33;
    rd0_val[0] = 1'b1; rd0_adr[0] = 8'd8;
    @(negedge clk);
    check("nocol_rdy", 32'({wr0_rdy[0], rd0_rdy[0]}), 32'b11);
    check("nocol_adr", 32'(sram_rd_adr[0]), 32'd8);
    step();
    idle_all();
    @(negedge clk);
    check("nocol_dat", rd_dat[0], 32'h88);
    check("nocol_rsp", 32'(rd0_rsp[0]), 32'd1);
    step();

    // RD_LAT=2: seed adr 10..13, then both readers back-to-back.
    for (int c = 0; c < 4; c++) begin
      wr0_val[1] = 1'b1; wr0_adr[1] = 8'(10 + c); wr0_dat[1] = 32'hC000_0000 | 32'(10 + c);
      @(negedge clk);
      check("l2_seed_rdy", 32'(wr0_rdy[1]), 32'd1);
      step();
    end
    idle_all();
    rd0_val[1] = 1'b1; rd0_adr[1] = 8'd10;
    rd1_val[1] = 1'b1; rd1_adr[1] = 8'd11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) begin
        check("l2_rd0_rdy", 32'(rd0_rdy[1]), 32'(c % 2 == 0));
        check("l2_rd1_rdy", 32'(rd1_rdy[1]), 32'(c % 2 == 1));
        check("l2_rd_adr", 32'(sram_rd_adr[1]), 32'(10 + c));
      end
      if (c >= 2) begin
        check("l2_rsp0", 32'(rd0_rsp[1]), 32'(c % 2 == 0));
        check("l2_rsp1", 32'(rd1_rsp[1]), 32'(c % 2 == 1));
        check("l2_dat", rd_dat[1], 32'hC000_0000 | 32'(10 + c - 2));
      end else begin
        check("l2_no_rsp", 32'({rd0_rsp[1], rd1_rsp[1]}), 32'd0);
      end
      step();
      if (c == 0) rd0_adr[1] = 8'd12;
      if (c == 1) rd1_adr[1] = 8'd13;
      if (c == 2) rd0_val[1] = 1'b0;
      if (c == 3) rd1_val[1] = 1'b0;
    end
    @(negedge clk);
    check("l2_err_clean", 32'(err[1]), 32'd0);

    // Drop the SRAM valid on one returning slot: err sets and stays until reset.
    rd0_val[1] = 1'b1; rd0_adr[1] = 8'd10;
    step();
    rd0_val[1] = 1'b0;
    step();
    kill[1] = 1'b1;
    @(negedge clk);
    check("kill_pre_err", 32'(err[1]), 32'd0);
    step();
    kill[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("err_sticky", 32'(err[1]), 32'd1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err[1]), 32'd0);
    step();

    // Reset the cycle after a read accept: its response must never appear.
    rd0_val[0] = 1'b1; rd0_adr[0] = 8'd5;
    @(negedge clk);
    check("r6_rdy", 32'(rd0_rdy[0]), 32'd1);
    step();
    rd0_val[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("r6_rsp_in_rst", 32'({rd0_rsp[0], rd1_rsp[0]}), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("r6_rsp_after", 32'({rd0_rsp[0], rd1_rsp[0], err[0]}), 32'd0);
    step();
    rd1_val[0] = 1'b1; rd1_adr[0] = 8'd5;
    @(negedge clk);
    check("r6_new_rdy", 32'(rd1_rdy[0]), 32'd1);
    step();
    rd1_val[0] = 1'b0;
    @(negedge clk);
    check("r6_new_rsp", 32'({rd1_rsp[0], rd0_rsp[0]}), 32'b10);
    check("r6_new_dat", rd_dat[0], 32'hA5A5A5A5);
    check("r6_err", 32'(err[0]), 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
